// File: rtl/deserializer.sv
// deserializer: serial-to-parallel front end for the byte queue.
// Bits arrive MSB first. Each assembled byte is handed downstream with a
// level-based data_ready/ack_in handshake.
// Ports: clock_100KHZ, reset (sync, active-low), data_in, write_in, ack_in
//        -> data_out[7:0], data_ready, status_out (1 = accepting bits).
// Macro DESERIALIZER_PARITY_EN: a 9th even-parity bit is collected per
// byte. A mismatch drops the byte and pulses parity_error_out.
module deserializer (
   input  logic       clock_100KHZ,
   input  logic       reset,
   input  logic       data_in,
   input  logic       write_in,
   input  logic       ack_in,
   output logic [7:0] data_out,
   output logic       data_ready,
   output logic       status_out
`ifdef DESERIALIZER_PARITY_EN
   ,
   output logic       parity_error_out
`endif
);

   localparam logic [1:0] RECEIVE = 2'd0;
   localparam logic [1:0] SEND    = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

`ifdef DESERIALIZER_PARITY_EN
   localparam int CW = 4;
   localparam logic [CW-1:0] LAST = 4'd8;
`else
   localparam int CW = 3;
   localparam logic [CW-1:0] LAST = 3'd7;
`endif
   localparam logic [CW-1:0] ONE = 1;

   logic [1:0]    state;
   logic [7:0]    shift;
   logic [CW-1:0] bit_cnt;

   always_ff @(posedge clock_100KHZ) begin
      if (!reset) begin
         state      <= RECEIVE;
         shift      <= 8'h00;
         bit_cnt    <= '0;
         data_out   <= 8'h00;
         data_ready <= 1'b0;
         status_out <= 1'b1;
`ifdef DESERIALIZER_PARITY_EN
         parity_error_out <= 1'b0;
`endif
      end else begin
`ifdef DESERIALIZER_PARITY_EN
         parity_error_out <= 1'b0;
`endif
         case (state)
            RECEIVE: begin
               if (write_in) begin
                  if (bit_cnt == LAST) begin
                     bit_cnt <= '0;
`ifdef DESERIALIZER_PARITY_EN
                     // Final bit is the even-parity bit; shift holds data.
                     if ((^shift) == data_in) begin
                        data_out   <= shift;
                        data_ready <= 1'b1;
                        status_out <= 1'b0;
                        state      <= SEND;
                     end else begin
                        parity_error_out <= 1'b1;
                     end
`else
                     shift      <= {shift[6:0], data_in};
                     data_out   <= {shift[6:0], data_in};
                     data_ready <= 1'b1;
                     status_out <= 1'b0;
                     state      <= SEND;
`endif
                  end else begin
                     shift   <= {shift[6:0], data_in};
                     bit_cnt <= bit_cnt + ONE;
                  end
               end
            end
            SEND: begin
               if (ack_in) begin
                  data_ready <= 1'b0;
                  state      <= RELEASE;
               end
            end
            RELEASE: begin
               // Wait for downstream to drop ack before taking new bits.
               if (!ack_in) begin
                  status_out <= 1'b1;
                  state      <= RECEIVE;
               end
            end
            default: begin
               state <= RECEIVE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed self-checking bench for deserializer.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_deserializer;

   logic       clk;
   logic       reset;
   logic       data_in;
   logic       write_in;
   logic       ack_in;
   logic [7:0] data_out;
   logic       data_ready;
   logic       status_out;
`ifdef DESERIALIZER_PARITY_EN
   logic       parity_error_out;
`endif

   int compared;
   int mismatched;

   deserializer dut (
      .clock_100KHZ     (clk),
      .reset            (reset),
      .data_in          (data_in),
      .write_in         (write_in),
      .ack_in           (ack_in),
      .data_out         (data_out),
      .data_ready       (data_ready),
      .status_out       (status_out)
`ifdef DESERIALIZER_PARITY_EN
      ,
      .parity_error_out (parity_error_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         data_in  = b[i];
         write_in = 1'b1;
         tick();
      end
`ifdef DESERIALIZER_PARITY_EN
      data_in  = ^b;
      write_in = 1'b1;
      tick();
`endif
      write_in = 1'b0;
      data_in  = 1'b0;
   endtask

   task automatic handshake();
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] b;
      compared   = 0;
      mismatched = 0;
      reset      = 1'b0;
      data_in    = 1'b0;
      write_in   = 1'b0;
      ack_in     = 1'b0;

      // Reset held for two edges
      tick();
      tick();
      check("rst_data", data_out, 8'h00);
      check("rst_ready", {7'd0, data_ready}, 8'd0);
      check("rst_status", {7'd0, status_out}, 8'd1);
      reset = 1'b1;
      tick();

      // Basic byte A5
      send_byte(8'hA5);
      check("a5_data", data_out, 8'hA5);
      check("a5_ready", {7'd0, data_ready}, 8'd1);
      check("a5_status", {7'd0, status_out}, 8'd0);
      tick();
      check("a5_hold", data_out, 8'hA5);
      check("a5_hold_rdy", {7'd0, data_ready}, 8'd1);
      ack_in = 1'b1;
      tick();
      check("a5_ack_rdy", {7'd0, data_ready}, 8'd0);
      check("a5_ack_st", {7'd0, status_out}, 8'd0);
      ack_in = 1'b0;
      tick();
      check("a5_rel_st", {7'd0, status_out}, 8'd1);

      // Gapped strobes for 3C, data_in toggled during gaps
      b = 8'h3C;
      for (int i = 7; i >= 0; i--) begin
         data_in  = b[i];
         write_in = 1'b1;
         tick();
         write_in = 1'b0;
         for (int g = 0; g < (i % 5) + 1; g++) begin
            data_in = ~b[i];
            tick();
         end
      end
`ifdef DESERIALIZER_PARITY_EN
      data_in  = ^b;
      write_in = 1'b1;
      tick();
      write_in = 1'b0;
      tick();
`endif
      check("gap_data", data_out, 8'h3C);
      check("gap_ready", {7'd0, data_ready}, 8'd1);

      // Busy drop: strobes during SEND are discarded
      for (int i = 0; i < 3; i++) begin
         data_in  = 1'b1;
         write_in = 1'b1;
         tick();
         write_in = 1'b0;
         tick();
      end
      check("busy_data", data_out, 8'h3C);
      check("busy_ready", {7'd0, data_ready}, 8'd1);
      handshake();
      send_byte(8'hF0);
      check("f0_data", data_out, 8'hF0);
      check("f0_ready", {7'd0, data_ready}, 8'd1);
      handshake();

      // ack already high when SEND is entered
      ack_in = 1'b1;
      send_byte(8'h5A);
      check("pre_ack_data", data_out, 8'h5A);
      check("pre_ack_rdy1", {7'd0, data_ready}, 8'd1);
      tick();
      check("pre_ack_rdy0", {7'd0, data_ready}, 8'd0);
      tick();
      check("pre_ack_st", {7'd0, status_out}, 8'd0);
      ack_in = 1'b0;
      tick();
      check("pre_ack_rel", {7'd0, status_out}, 8'd1);

      // Reset after 5 of 8 bits
      for (int i = 0; i < 5; i++) begin
         data_in  = 1'b1;
         write_in = 1'b1;
         tick();
      end
      write_in = 1'b0;
      reset    = 1'b0;
      tick();
      reset = 1'b1;
      check("mid_rst_rdy", {7'd0, data_ready}, 8'd0);
      check("mid_rst_st", {7'd0, status_out}, 8'd1);
      check("mid_rst_data", data_out, 8'h00);
      send_byte(8'h81);
      check("r81_data", data_out, 8'h81);
      check("r81_ready", {7'd0, data_ready}, 8'd1);

      // Reset while in SEND abandons the byte
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("send_rst_rdy", {7'd0, data_ready}, 8'd0);
      check("send_rst_st", {7'd0, status_out}, 8'd1);
      check("send_rst_data", data_out, 8'h00);
      tick();

`ifdef DESERIALIZER_PARITY_EN
      // 03 with parity 0 is accepted
      send_byte(8'h03);
      check("par_ok_data", data_out, 8'h03);
      check("par_ok_rdy", {7'd0, data_ready}, 8'd1);
      check("par_ok_err", {7'd0, parity_error_out}, 8'd0);
      handshake();
      // 07 with parity 0 is rejected
      b = 8'h07;
      for (int i = 7; i >= 0; i--) begin
         data_in  = b[i];
         write_in = 1'b1;
         tick();
      end
      data_in = 1'b0;
      tick();
      write_in = 1'b0;
      check("par_bad_err", {7'd0, parity_error_out}, 8'd1);
      check("par_bad_rdy", {7'd0, data_ready}, 8'd0);
      check("par_bad_st", {7'd0, status_out}, 8'd1);
      check("par_bad_data", data_out, 8'h03);
      tick();
      check("par_bad_pulse", {7'd0, parity_error_out}, 8'd0);
      send_byte(8'h42);
      check("par_next", data_out, 8'h42);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
